// File: rtl/div_seq_pkg.sv
// ============================================================================
// Module   : div_seq_pkg
// Purpose  : Shared opcode constants, FSM state encoding and opcode helper
//            functions for the sequential integer divider.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package div_seq_pkg;

    // M-extension divide opcodes as issued by the decode stage
    localparam logic [4:0] ALU_DIV  = 5'd12;
    localparam logic [4:0] ALU_DIVU = 5'd13;
    localparam logic [4:0] ALU_REM  = 5'd14;
    localparam logic [4:0] ALU_REMU = 5'd15;

    // Divider sequencer states
    typedef enum logic [2:0] {
        DIVSEQ_IDLE  = 3'd0,
        DIVSEQ_SETUP = 3'd1,
        DIVSEQ_ITER  = 3'd2,
        DIVSEQ_FIXUP = 3'd3,
        DIVSEQ_DONE  = 3'd4
    } divseq_state_t;

    function automatic logic is_valid_op(input logic [4:0] op);
        return (op == ALU_DIV) || (op == ALU_DIVU) ||
               (op == ALU_REM) || (op == ALU_REMU);
    endfunction

    function automatic logic is_signed_op(input logic [4:0] op);
        return (op == ALU_DIV) || (op == ALU_REM);
    endfunction

    function automatic logic is_div_op(input logic [4:0] op);
        return (op == ALU_DIV) || (op == ALU_DIVU);
    endfunction

endpackage : div_seq_pkg

`default_nettype wire

// File: rtl/div_seq_step.sv
// ============================================================================
// Module   : div_step
// Purpose  : One radix-2 restoring division step: shift the next dividend
//            bit into the partial remainder, trial-subtract the divisor and
//            keep the difference only when it is non-negative.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_step #(
    parameter int W = 32
) (
    input  logic [W:0]   rem_in,
    input  logic         dividend_bit,
    input  logic [W-1:0] divisor,
    output logic [W:0]   rem_out,
    output logic         q_bit
);

    logic [W+1:0] w_shifted;
    logic [W+1:0] w_trial;
    logic         w_neg;

    // The incoming remainder is always below the divisor, so the shifted
    // value fits in W+1 bits and bit W+1 of the trial is a clean borrow.
    always_comb begin
        w_shifted = {rem_in, dividend_bit};
        w_trial   = w_shifted - {2'b00, divisor};
        w_neg     = w_trial[W+1];
        q_bit     = ~w_neg;
        rem_out   = w_neg ? w_shifted[W:0] : w_trial[W:0];
    end

endmodule : div_step

`default_nettype wire

// File: rtl/div_seq.sv
// ============================================================================
// Module   : div_seq
// Purpose  : Multi-cycle restoring divider for DIV/DIVU/REM/REMU and their
//            RV64 W-forms, with valid/ready handshakes and a flush input.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_seq
    import div_seq_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            kill,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      opcode,
    input  logic            s_32,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] rd
);

    localparam int                  c_cnt_w  = $clog2(XLEN);
    localparam logic [c_cnt_w-1:0]  c_last_w = c_cnt_w'(31);
    localparam logic [c_cnt_w-1:0]  c_last_x = c_cnt_w'(XLEN - 1);

    function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] v);
        logic [XLEN-1:0] r;
        r = v;
        for (int i = 32; i < XLEN; i++) r[i] = v[31];
        return r;
    endfunction

    function automatic logic [XLEN-1:0] zext32(input logic [XLEN-1:0] v);
        logic [XLEN-1:0] r;
        r       = '0;
        r[31:0] = v[31:0];
        return r;
    endfunction

    divseq_state_t      r_state;
    logic               r_in_ready;
    logic               r_out_valid;
    logic [XLEN-1:0]    r_rd;
    logic [c_cnt_w-1:0] r_cnt;
    logic [4:0]         r_op;
    logic               r_w;
    logic [XLEN-1:0]    r_dividend;
    logic [XLEN-1:0]    r_divisor;
    logic [XLEN:0]      r_rem;
    logic [XLEN-1:0]    r_quot;
    logic               r_q_neg;
    logic               r_r_neg;

    logic               w_s32;
    logic [XLEN-1:0]    w_rs1_ext;
    logic [XLEN-1:0]    w_rs2_ext;
    logic               w_signed;
    logic               w_is_div;
    logic [XLEN-1:0]    w_min_neg;
    logic               w_div_zero;
    logic               w_ovf;
    logic               w_special_case;
    logic [XLEN-1:0]    w_special;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [XLEN-1:0]    w_a_abs;
    logic [XLEN-1:0]    w_b_abs;
    logic [XLEN:0]      w_rem_next;
    logic               w_q_bit;
    logic [XLEN-1:0]    w_res_raw;
    logic [XLEN-1:0]    w_res_sgn;
    logic [XLEN-1:0]    w_fix;

    // Operand extension at acceptance and setup-time classification
    always_comb begin
        w_s32     = (XLEN == 32) ? 1'b0 : s_32;
        w_rs1_ext = rs1;
        w_rs2_ext = rs2;
        if (w_s32) begin
            w_rs1_ext = is_signed_op(opcode) ? sext32(rs1) : zext32(rs1);
            w_rs2_ext = is_signed_op(opcode) ? sext32(rs2) : zext32(rs2);
        end

        w_signed   = is_signed_op(r_op);
        w_is_div   = is_div_op(r_op);
        w_min_neg  = r_w ? sext32(XLEN'(32'h8000_0000)) : {1'b1, {(XLEN-1){1'b0}}};
        w_div_zero = (r_divisor == '0);
        w_ovf      = w_signed && (r_dividend == w_min_neg) && (r_divisor == '1);
        w_special_case = !is_valid_op(r_op) || w_div_zero || w_ovf;

        // Divide-by-zero and overflow can never coincide (divisor 0 vs -1)
        w_special = '0;
        if (!is_valid_op(r_op))
            w_special = '0;
        else if (w_div_zero)
            w_special = w_is_div ? '1 : (r_w ? sext32(r_dividend) : r_dividend);
        else if (w_ovf)
            w_special = w_is_div ? r_dividend : '0;

        // W-form operands are already sign-extended, so the MSB is the sign
        w_a_neg = w_signed && r_dividend[XLEN-1];
        w_b_neg = w_signed && r_divisor[XLEN-1];
        w_a_abs = w_a_neg ? ('0 - r_dividend) : r_dividend;
        w_b_abs = w_b_neg ? ('0 - r_divisor)  : r_divisor;

        w_res_raw = w_is_div ? r_quot : r_rem[XLEN-1:0];
        w_res_sgn = (w_is_div ? r_q_neg : r_r_neg) ? ('0 - w_res_raw) : w_res_raw;
        w_fix     = r_w ? sext32(w_res_sgn) : w_res_sgn;
    end

    div_step #(
        .W (XLEN)
    ) u_step (
        .rem_in       (r_rem),
        .dividend_bit (r_dividend[r_cnt]),
        .divisor      (r_divisor),
        .rem_out      (w_rem_next),
        .q_bit        (w_q_bit)
    );

    // Sequencer: accept, classify, iterate MSB-first, fix signs, hand off
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= DIVSEQ_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_rd        <= '0;
            r_cnt       <= '0;
            r_op        <= '0;
            r_w         <= 1'b0;
            r_dividend  <= '0;
            r_divisor   <= '0;
            r_rem       <= '0;
            r_quot      <= '0;
            r_q_neg     <= 1'b0;
            r_r_neg     <= 1'b0;
        end else if (kill) begin
            r_state     <= DIVSEQ_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                DIVSEQ_IDLE: begin
                    if (in_valid) begin
                        r_op       <= opcode;
                        r_w        <= w_s32;
                        r_dividend <= w_rs1_ext;
                        r_divisor  <= w_rs2_ext;
                        r_in_ready <= 1'b0;
                        r_state    <= DIVSEQ_SETUP;
                    end
                end
                DIVSEQ_SETUP: begin
                    if (w_special_case) begin
                        r_rd        <= w_special;
                        r_out_valid <= 1'b1;
                        r_state     <= DIVSEQ_DONE;
                    end else begin
                        r_dividend <= w_a_abs;
                        r_divisor  <= w_b_abs;
                        r_q_neg    <= w_a_neg ^ w_b_neg;
                        r_r_neg    <= w_a_neg;
                        r_rem      <= '0;
                        r_quot     <= '0;
                        r_cnt      <= r_w ? c_last_w : c_last_x;
                        r_state    <= DIVSEQ_ITER;
                    end
                end
                DIVSEQ_ITER: begin
                    r_rem  <= w_rem_next;
                    r_quot <= {r_quot[XLEN-2:0], w_q_bit};
                    if (r_cnt == '0)
                        r_state <= DIVSEQ_FIXUP;
                    else
                        r_cnt <= r_cnt - 1'b1;
                end
                DIVSEQ_FIXUP: begin
                    r_rd        <= w_fix;
                    r_out_valid <= 1'b1;
                    r_state     <= DIVSEQ_DONE;
                end
                DIVSEQ_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= DIVSEQ_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= DIVSEQ_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign rd        = r_rd;

endmodule : div_seq

`default_nettype wire

// File: tb/tb_div_seq.sv
// ============================================================================
// Module   : tb_div_seq
// Purpose  : Self-checking bench for div_seq (XLEN=64 and XLEN=32 instances):
//            vector table with latency checks, scoreboard on results, and
//            hand-written kill / back-pressure / mid-operation reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_div_seq;
    import div_seq_pkg::*;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        kill;
    logic        out_ready;
    logic [4:0]  opcode;
    logic        s_32;

    logic        iv64, ir64, ov64;
    logic [63:0] a64, b64, rd64;
    logic        iv32, ir32, ov32;
    logic [31:0] a32, b32, rd32;

    div_seq #(.XLEN(64)) u_dut64 (
        .clk (clk), .rst_n (rst_n), .kill (kill),
        .in_valid (iv64), .in_ready (ir64), .opcode (opcode), .s_32 (s_32),
        .rs1 (a64), .rs2 (b64), .out_valid (ov64), .out_ready (out_ready),
        .rd (rd64)
    );

    div_seq #(.XLEN(32)) u_dut32 (
        .clk (clk), .rst_n (rst_n), .kill (kill),
        .in_valid (iv32), .in_ready (ir32), .opcode (opcode), .s_32 (s_32),
        .rs1 (a32), .rs2 (b32), .out_valid (ov32), .out_ready (out_ready),
        .rd (rd32)
    );

    typedef struct {
        bit          d32;
        logic [4:0]  op;
        bit          s;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
        int          lat;
        string       name;
    } vec_t;

    int          errs   = 0;
    int          checks = 0;
    logic [63:0] sb_q[$];
    vec_t        tbl[24];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input bit d32, input logic [4:0] op, input bit s,
                                input logic [63:0] a, input logic [63:0] b,
                                input logic [63:0] e, input int lat, input string n);
        vec_t v;
        v.d32 = d32; v.op = op; v.s = s; v.a = a; v.b = b;
        v.exp = e; v.lat = lat; v.name = n;
        return v;
    endfunction

    // Drive one operation, measure latency to out_valid, score the result
    task automatic run_op(input vec_t v);
        int          cyc;
        logic [63:0] exp;
        logic [63:0] got;
        cyc = 0;
        while (!(v.d32 ? ir32 : ir64) && cyc < 200) begin
            @(posedge clk); #1; cyc++;
        end
        check({v.name, " in_ready"}, {63'd0, (v.d32 ? ir32 : ir64)}, 64'd1);
        opcode = v.op;
        s_32   = v.s;
        if (v.d32) begin a32 = v.a[31:0]; b32 = v.b[31:0]; iv32 = 1'b1; end
        else       begin a64 = v.a;       b64 = v.b;       iv64 = 1'b1; end
        @(posedge clk); #1;
        iv32 = 1'b0;
        iv64 = 1'b0;
        sb_q.push_back(v.exp);
        cyc = 1;
        while (!(v.d32 ? ov32 : ov64) && cyc < 200) begin
            @(posedge clk); #1; cyc++;
        end
        check({v.name, " latency"}, 64'(cyc), 64'(v.lat));
        got = v.d32 ? {32'd0, rd32} : rd64;
        exp = sb_q.pop_front();
        check({v.name, " rd"}, got, exp);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        bit          ok;
        int          cyc;
        logic [63:0] held;

        rst_n = 1'b0; kill = 1'b0; out_ready = 1'b0; opcode = '0; s_32 = 1'b0;
        iv64 = 1'b0; a64 = '0; b64 = '0; iv32 = 1'b0; a32 = '0; b32 = '0;

        tbl[0]  = mk(0, ALU_DIV,  0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 67, "div_m7_2");
        tbl[1]  = mk(0, ALU_REM,  0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 67, "rem_m7_2");
        tbl[2]  = mk(0, ALU_DIVU, 1, 64'hFFFF_FFFF_0000_0010, 64'd3, 64'd5, 35, "divuw_hi_ign");
        tbl[3]  = mk(0, ALU_REM,  1, 64'h0000_0000_8000_0001, 64'd0, 64'hFFFF_FFFF_8000_0001, 2, "remw_by0");
        tbl[4]  = mk(0, ALU_DIVU, 0, 64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 2, "divu_by0");
        tbl[5]  = mk(0, ALU_DIVU, 0, 64'd100, 64'd7, 64'd14, 67, "divu_100_7");
        tbl[6]  = mk(0, ALU_REMU, 0, 64'd100, 64'd7, 64'd2, 67, "remu_100_7");
        tbl[7]  = mk(0, ALU_DIV,  0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 2, "div_ovf");
        tbl[8]  = mk(0, ALU_REM,  0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 2, "rem_ovf");
        tbl[9]  = mk(0, ALU_DIV,  1, 64'h1234_5678_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 2, "divw_ovf");
        tbl[10] = mk(0, ALU_REM,  1, 64'hABCD_0000_FFFF_FFF9, 64'h5555_0000_0000_0002, 64'hFFFF_FFFF_FFFF_FFFF, 35, "remw_m7_2");
        tbl[11] = mk(0, ALU_DIV,  1, 64'h7777_0000_0000_0014, 64'h0000_0000_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFA, 35, "divw_20_m3");
        tbl[12] = mk(0, ALU_REM,  1, 64'h7777_0000_0000_0014, 64'h0000_0000_FFFF_FFFD, 64'd2, 35, "remw_20_m3");
        tbl[13] = mk(0, 5'd0,     0, 64'd5, 64'd3, 64'd0, 2, "bad_opcode");
        tbl[14] = mk(0, ALU_DIV,  0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, 67, "div_7_m2");
        tbl[15] = mk(0, ALU_REMU, 1, 64'h0000_0001_FFFF_FFFF, 64'h10, 64'hF, 35, "remuw_mask");
        tbl[16] = mk(0, ALU_DIVU, 1, 64'h0000_0000_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 35, "divuw_sext");
        tbl[17] = mk(1, ALU_DIV,  0, 64'h8000_0000, 64'hFFFF_FFFF, 64'h8000_0000, 2, "div32_ovf");
        tbl[18] = mk(1, ALU_REM,  0, 64'h8000_0000, 64'hFFFF_FFFF, 64'd0, 2, "rem32_ovf");
        tbl[19] = mk(1, ALU_DIV,  1, 64'hFFFF_FFF9, 64'd2, 64'hFFFF_FFFD, 35, "div32_m7_2");
        tbl[20] = mk(1, ALU_REMU, 0, 64'hFFFF_FFFF, 64'd7, 64'd3, 35, "remu32_max_7");
        tbl[21] = mk(1, ALU_DIVU, 0, 64'd9, 64'd0, 64'hFFFF_FFFF, 2, "divu32_by0");
        tbl[22] = mk(0, ALU_DIV,  0, 64'hFFFF_FFFF_FFFF_FF9C, 64'hFFFF_FFFF_FFFF_FFF9, 64'd14, 67, "div_m100_m7");
        tbl[23] = mk(0, ALU_REM,  0, 64'hFFFF_FFFF_FFFF_FF9C, 64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFFE, 67, "rem_m100_m7");

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst in_ready64", {63'd0, ir64}, 64'd1);
        check("rst out_valid64", {63'd0, ov64}, 64'd0);
        check("rst rd64", rd64, 64'd0);
        check("rst in_ready32", {63'd0, ir32}, 64'd1);
        check("rst out_valid32", {63'd0, ov32}, 64'd0);
        check("rst rd32", {32'd0, rd32}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 24; i++) run_op(tbl[i]);

        // Kill during ITER with in_valid held high
        opcode = ALU_DIV; s_32 = 1'b0; a64 = 64'd1000; b64 = 64'd7; iv64 = 1'b1;
        @(posedge clk); #1;
        repeat (11) @(posedge clk);
        #1;
        kill = 1'b1;
        @(posedge clk); #1;
        check("kill in_ready", {63'd0, ir64}, 64'd1);
        check("kill out_valid", {63'd0, ov64}, 64'd0);
        @(posedge clk); #1;
        check("kill wins in_ready", {63'd0, ir64}, 64'd1);
        kill = 1'b0; iv64 = 1'b0;
        ok = 1'b1;
        repeat (80) begin
            @(posedge clk); #1;
            if (ov64 || !ir64) ok = 1'b0;
        end
        check("kill no out_valid", {63'd0, ok}, 64'd1);
        run_op(mk(0, ALU_DIV, 0, 64'd1000, 64'd7, 64'd142, 67, "after_kill"));

        // Back-pressure: hold out_ready low in DONE
        opcode = ALU_DIVU; s_32 = 1'b0; a64 = 64'd100; b64 = 64'd7; iv64 = 1'b1;
        @(posedge clk); #1;
        iv64 = 1'b0;
        sb_q.push_back(64'd14);
        cyc = 1;
        while (!ov64 && cyc < 200) begin
            @(posedge clk); #1; cyc++;
        end
        check("stall reach done", 64'(cyc), 64'd67);
        held = rd64;
        check("stall rd", held, sb_q.pop_front());
        ok = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            if (!ov64 || ir64 || rd64 !== held) ok = 1'b0;
        end
        check("stall stable", {63'd0, ok}, 64'd1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("release in_ready", {63'd0, ir64}, 64'd1);
        check("release out_valid", {63'd0, ov64}, 64'd0);
        check("release rd held", rd64, 64'd14);

        // Synchronous reset in the middle of ITER
        opcode = ALU_DIV; s_32 = 1'b0; a64 = 64'd555; b64 = 64'd5; iv64 = 1'b1;
        @(posedge clk); #1;
        iv64 = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midrst in_ready", {63'd0, ir64}, 64'd1);
        check("midrst out_valid", {63'd0, ov64}, 64'd0);
        check("midrst rd", rd64, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(mk(0, ALU_DIV, 0, 64'd555, 64'd5, 64'd111, 67, "after_rst"));

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule : tb_div_seq

`default_nettype wire
